// File: rtl/pipe_mult_hs.sv
// ---------------------------------------------------------------------------
// pipe_mult_hs
//
// Fully pipelined integer multiplier with valid/ready handshaking on both
// sides. Each operation carries its own signed/unsigned mode and an opaque
// tag. The block produces the full double-width product. It accepts one
// operation per clock. The whole pipeline freezes while the output register
// holds a result that the consumer has not taken.
//
// Parameters
//   BIT_WIDTH  operand width (even, >= 4)
//   STAGES     pipeline depth, must divide BIT_WIDTH evenly
//   TAG_WIDTH  width of the tag passed through with each operation
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   valid_i       an operation is presented
//   ready_o       the presented operation is accepted this cycle
//   multiplier_i  operand A
//   multicand_i   operand B
//   signed_i      1: both operands two's complement, 0: both unsigned
//   tag_i         opaque tag for the operation
//   valid_o       a result is presented
//   ready_i       consumer takes the presented result
//   product_o     full 2*BIT_WIDTH product
//   tag_o         tag of the presented result
// ---------------------------------------------------------------------------
module pipe_mult_hs #(
  parameter int BIT_WIDTH = 32,
  parameter int STAGES    = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [BIT_WIDTH-1:0]   multiplier_i,
  input  logic [BIT_WIDTH-1:0]   multicand_i,
  input  logic                   signed_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [2*BIT_WIDTH-1:0] product_o,
  output logic [TAG_WIDTH-1:0]   tag_o
);

  localparam int PW  = 2 * BIT_WIDTH;
  localparam int BPS = BIT_WIDTH / STAGES;

  // Adds the multiplicand, shifted by the bit position, for each set bit
  // of the multiplier chunk that this stage retires.
  function automatic logic [PW-1:0] chunk_sum(
    input logic [PW-1:0]  psum,
    input logic [PW-1:0]  mcand,
    input logic [BPS-1:0] bits
  );
    logic [PW-1:0] acc;
    acc = psum;
    for (int j = 0; j < BPS; j++) begin
      if (bits[j]) begin
        acc = acc + (mcand << j);
      end
    end
    return acc;
  endfunction

  // Stage registers. Stage 0 holds a freshly accepted operation with a zero
  // partial sum. Each hop to the next stage, including the hop into the
  // output register, retires BPS multiplier bits.
  logic                 st_valid [STAGES];
  logic [PW-1:0]        st_psum  [STAGES];
  logic [PW-1:0]        st_mcand [STAGES];
  logic [BIT_WIDTH-1:0] st_mplier[STAGES];
  logic                 st_sign  [STAGES];
  logic [TAG_WIDTH-1:0] st_tag   [STAGES];

  logic [PW-1:0]        nx_psum  [STAGES];

  logic                 advance;
  logic                 accept;
  logic [BIT_WIDTH-1:0] mag_a;
  logic [BIT_WIDTH-1:0] mag_b;
  logic                 entry_sign;
  logic [PW-1:0]        final_product;

  // The pipeline moves only when the output slot is free or is being taken.
  // ready_o depends only on the output side, so it never waits on valid_i.
  assign advance = ready_i | ~valid_o;
  assign ready_o = advance;
  assign accept  = valid_i & advance;

  // Entry conversion to sign/magnitude. Unary minus over BIT_WIDTH bits maps
  // the most negative value onto 2^(BIT_WIDTH-1), which is its correct
  // unsigned magnitude.
  always_comb begin
    mag_a      = multiplier_i;
    mag_b      = multicand_i;
    entry_sign = 1'b0;
    if (signed_i) begin
      if (multiplier_i[BIT_WIDTH-1]) begin
        mag_a = -multiplier_i;
      end
      if (multicand_i[BIT_WIDTH-1]) begin
        mag_b = -multicand_i;
      end
      entry_sign = multiplier_i[BIT_WIDTH-1] ^ multicand_i[BIT_WIDTH-1];
    end
  end

  // Partial sum that each stage hands on to its successor.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      nx_psum[i] = chunk_sum(st_psum[i], st_mcand[i], st_mplier[i][BPS-1:0]);
    end
  end

  // The last hop restores the sign with a two's complement negate over the
  // full product width.
  always_comb begin
    final_product = nx_psum[STAGES-1];
    if (st_sign[STAGES-1]) begin
      final_product = -nx_psum[STAGES-1];
    end
  end

  // Pipeline advance. Data registers load only behind a valid bit, so
  // bubbles leave stale data in place. The output register changes only
  // when a real result arrives, so it stays at zero after reset until the
  // first new result is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        st_valid[i]  <= 1'b0;
        st_psum[i]   <= '0;
        st_mcand[i]  <= '0;
        st_mplier[i] <= '0;
        st_sign[i]   <= 1'b0;
        st_tag[i]    <= '0;
      end
      valid_o   <= 1'b0;
      product_o <= '0;
      tag_o     <= '0;
    end else if (advance) begin
      st_valid[0] <= accept;
      if (accept) begin
        st_psum[0]   <= '0;
        st_mcand[0]  <= {{BIT_WIDTH{1'b0}}, mag_b};
        st_mplier[0] <= mag_a;
        st_sign[0]   <= entry_sign;
        st_tag[0]    <= tag_i;
      end
      for (int i = 1; i < STAGES; i++) begin
        st_valid[i] <= st_valid[i-1];
        if (st_valid[i-1]) begin
          st_psum[i]   <= nx_psum[i-1];
          st_mcand[i]  <= st_mcand[i-1] << BPS;
          st_mplier[i] <= st_mplier[i-1] >> BPS;
          st_sign[i]   <= st_sign[i-1];
          st_tag[i]    <= st_tag[i-1];
        end
      end
      valid_o <= st_valid[STAGES-1];
      if (st_valid[STAGES-1]) begin
        product_o <= final_product;
        tag_o     <= st_tag[STAGES-1];
      end
    end
  end

endmodule
